ternary_stream_feeder: RTL



---
 rtl/ternary_stream_feeder.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/ternary_stream_feeder.sv
// rtl/ternary_stream_feeder.sv - host-side slot feeder and result capture for the 1.58-bit systolic tile
module ternary_stream_feeder #(
    parameter int SLICES  = 4,
    parameter int ROWS    = 16,
    parameter int RESULTS = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] cfg_groups,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_weights,
    input  logic [7:0] in_act,
    output logic [7:0] ui_out,
    output logic [7:0] uio_out,
    output logic       ena_out,
    input  logic [7:0] uo_in,
    output logic       res_valid,
    output logic [3:0] res_index,
    output logic [7:0] res_data,
    output logic       frame_done,
    output logic       err_code,
    output logic       overrun
);
    localparam int            LANES     = ROWS / SLICES;
    localparam int            SW        = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam int            CW        = SW + 1;
    localparam logic [SW-1:0] LAST_SLOT = SW'(SLICES - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(SLICES);
    localparam logic [3:0]    LAST_RES  = 4'(RESULTS - 1);

    typedef enum logic [1:0] {
        FEED    = 2'd0,
        DRAIN   = 2'd1,
        READOUT = 2'd2
    } state_t;

    state_t        state;
    logic [SW-1:0] slot;
    logic [SW-1:0] slot_nx;
    logic [CW-1:0] fill_cnt;
    logic [7:0]    fill_w [SLICES];
    logic [7:0]    fill_a [SLICES];
    logic [7:0]    emit_w [SLICES];
    logic [7:0]    emit_a [SLICES];
    logic [7:0]    grp_cnt;
    logic [7:0]    grp_target;
    logic          cap_active;
    logic [3:0]    cap_idx;

    logic          boundary;
    logic          fill_full;
    logic          target_hit;
    logic          xfer;
    logic          accept;
    logic          readout_start;
    logic [7:0]    beat_w;
    logic          beat_bad;

    // Host lane k (2-bit two's complement) maps to tile row offset k, MSB-first on ui_out.
    always_comb begin
        beat_w   = '0;
        beat_bad = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            case (in_weights[2*k +: 2])
                2'b01:   beat_w[7-2*k -: 2] = 2'b01;
                2'b11:   beat_w[7-2*k -: 2] = 2'b10;
                2'b10:   beat_bad = 1'b1;
                default: beat_w[7-2*k -: 2] = 2'b00;
            endcase
        end
    end

    always_comb begin
        boundary      = (slot == LAST_SLOT);
        slot_nx       = boundary ? '0 : slot + SW'(1);
        fill_full     = (fill_cnt == FULL_CNT);
        target_hit    = (state == FEED) && (grp_cnt != 8'd0) && (grp_cnt == grp_target);
        xfer          = boundary && fill_full && (state != DRAIN) && !target_hit;
        in_ready      = !fill_full || xfer;
        accept        = in_valid && in_ready;
        readout_start = boundary && (state == DRAIN);
    end

    // Staging: fill buffer collects host beats, emit buffer holds the group on the pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_cnt <= '0;
            err_code <= 1'b0;
            for (int i = 0; i < SLICES; i++) begin
                fill_w[i] <= '0;
                fill_a[i] <= '0;
                emit_w[i] <= '0;
                emit_a[i] <= '0;
            end
        end else begin
            if (xfer) begin
                for (int i = 0; i < SLICES; i++) begin
                    emit_w[i] <= fill_w[i];
                    emit_a[i] <= fill_a[i];
                end
                if (accept) begin
                    fill_w[0] <= beat_w;
                    fill_a[0] <= in_act;
                    fill_cnt  <= CW'(1);
                end else begin
                    fill_cnt  <= '0;
                end
            end else begin
                if (boundary) begin
                    for (int i = 0; i < SLICES; i++) begin
                        emit_w[i] <= '0;
                        emit_a[i] <= '0;
                    end
                end
                if (accept) begin
                    fill_w[fill_cnt[SW-1:0]] <= beat_w;
                    fill_a[fill_cnt[SW-1:0]] <= in_act;
                    fill_cnt <= fill_cnt + CW'(1);
                end
            end
            if (accept && beat_bad) begin
                err_code <= 1'b1;
            end
        end
    end

    // Pin drivers: slot 0 of a new group comes straight from the fill buffer on transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ui_out     <= '0;
            uio_out    <= '0;
            ena_out    <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            if (boundary) begin
                ui_out  <= xfer ? fill_w[0] : 8'd0;
                uio_out <= xfer ? fill_a[0] : 8'd0;
            end else begin
                ui_out  <= emit_w[slot_nx];
                uio_out <= emit_a[slot_nx];
            end
            ena_out    <= !readout_start;
            frame_done <= readout_start;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot       <= '0;
            state      <= FEED;
            grp_cnt    <= '0;
            grp_target <= 8'd1;
        end else begin
            slot <= slot_nx;
            if (boundary) begin
                if (state == DRAIN) begin
                    state <= READOUT;
                end else if (target_hit) begin
                    state   <= DRAIN;
                    grp_cnt <= '0;
                end else begin
                    state <= FEED;
                    if (xfer) begin
                        grp_cnt <= grp_cnt + 8'd1;
                        if (grp_cnt == 8'd0) begin
                            grp_target <= (cfg_groups == 8'd0) ? 8'd1 : cfg_groups;
                        end
                    end
                end
            end
        end
    end

    // A readout that lands mid-capture still delivers the byte sampled that cycle, then restarts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_active <= 1'b0;
            cap_idx    <= '0;
            res_valid  <= 1'b0;
            res_index  <= '0;
            res_data   <= '0;
            overrun    <= 1'b0;
        end else begin
            res_valid <= cap_active;
            if (cap_active) begin
                res_index <= cap_idx;
                res_data  <= uo_in;
            end
            if (!ena_out) begin
                cap_active <= 1'b1;
                cap_idx    <= '0;
                if (cap_active && (cap_idx != LAST_RES)) begin
                    overrun <= 1'b1;
                end
            end else if (cap_active) begin
                cap_idx <= cap_idx + 4'd1;
                if (cap_idx == LAST_RES) begin
                    cap_active <= 1'b0;
                end
            end
        end
    end
endmodule
